// File: rtl/global_package.sv
// Shared types for the lane response arbiter.
//   MemoryPacketArbitrate   - route descriptor; id_lane carries the lane mask
//   FIFOStateSignalsOutput  - status bundle driven by a FIFO
//   FIFOStateSignalsInput   - control bundle driven into a FIFO
//   lane_response_arbiter_state_t - arbiter FSM state encoding
package global_package;

   localparam int CU_ID_W     = 8;
   localparam int BUNDLE_ID_W = 8;
   localparam int LANE_ID_W   = 8;

   typedef struct packed {
      logic [CU_ID_W-1:0]     id_cu;
      logic [BUNDLE_ID_W-1:0] id_bundle;
      logic [LANE_ID_W-1:0]   id_lane;
   } MemoryPacketArbitrate;

   typedef struct packed {
      logic full;
      logic empty;
      logic prog_full;
      logic valid;
   } FIFOStateSignalsOutput;

   typedef struct packed {
      logic rd_en;
      logic wr_en;
   } FIFOStateSignalsInput;

   typedef enum logic [1:0] {
      S_UNCFG = 2'd0,
      S_IDLE  = 2'd1,
      S_BURST = 2'd2
   } lane_response_arbiter_state_t;

endpackage

// File: rtl/lane_response_rr_arbiter_select.sv
// Wrap-around first-one search: returns the first set bit of eligible at or
// above rr_ptr, wrapping past the top lane back to lane 0.
//   eligible  - candidate lanes
//   rr_ptr    - lane where the search starts (must be < NUM_LANES)
//   grant     - one-hot winner, zero when nothing is eligible
//   grant_idx - binary index of the winner
//   found     - at least one lane was eligible
module rr_priority_select #(
   parameter int NUM_LANES = 4,
   parameter int PTR_W     = 2
) (
   input  logic [NUM_LANES-1:0] eligible,
   input  logic [PTR_W-1:0]     rr_ptr,
   output logic [NUM_LANES-1:0] grant,
   output logic [PTR_W-1:0]     grant_idx,
   output logic                 found
);

   localparam int SUM_W = PTR_W + 1;

   logic [SUM_W-1:0] pos;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      pos       = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         pos = {1'b0, rr_ptr} + SUM_W'(k);
         if (pos >= SUM_W'(NUM_LANES)) begin
            pos = pos - SUM_W'(NUM_LANES);
         end
         if (!found && eligible[pos[PTR_W-1:0]]) begin
            found                    = 1'b1;
            grant[pos[PTR_W-1:0]]    = 1'b1;
            grant_idx                = pos[PTR_W-1:0];
         end
      end
   end

endmodule

// File: rtl/lane_response_rr_arbiter.sv
// Round-robin arbiter that hands engine-response FIFO reads to requesting
// lanes in bursts of up to BURST_MAX reads.
//   ap_clk / areset_n                       - clock, async active-low reset
//   configure_route_valid / _in             - route strobe; id_lane = lane mask
//   lane_req_in                             - per-lane request
//   fifo_response_lanes_backtrack_signals_in- per-lane FIFO status (prog_full)
//   fifo_response_engine_out_signals_in     - engine FIFO status (empty)
//   fifo_response_engine_in_signals_out     - engine FIFO control (rd_en)
//   grant_out / grant_valid_out             - one-hot owner of current read
//
// state   | meaning
// S_UNCFG | no route seen since reset, never grants
// S_IDLE  | configured, waiting for an eligible lane
// S_BURST | one lane owns the engine FIFO read port
module lane_response_rr_arbiter
   import global_package::*;
#(
   parameter int ID_CU           = 0,
   parameter int ID_BUNDLE       = 0,
   parameter int NUM_LANES_MAX   = 4,
   parameter int NUM_BUNDLES_MAX = 4,
   parameter int BURST_MAX       = 4
) (
   input  logic                     ap_clk,
   input  logic                     areset_n,
   input  logic                     configure_route_valid,
   input  MemoryPacketArbitrate     configure_route_in,
   input  logic [NUM_LANES_MAX-1:0] lane_req_in,
   input  FIFOStateSignalsOutput    fifo_response_lanes_backtrack_signals_in [NUM_LANES_MAX-1:0],
   input  FIFOStateSignalsOutput    fifo_response_engine_out_signals_in,
   output FIFOStateSignalsInput     fifo_response_engine_in_signals_out,
   output logic [NUM_LANES_MAX-1:0] grant_out,
   output logic                     grant_valid_out
);

   localparam int PTR_W = (NUM_LANES_MAX > 1) ? $clog2(NUM_LANES_MAX) : 1;
   localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
   localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_LANES_MAX - 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);

   logic                     cfg_valid_reg;
   logic [NUM_LANES_MAX-1:0] cfg_lane_reg;
   logic [NUM_LANES_MAX-1:0] req_reg;
   logic [NUM_LANES_MAX-1:0] prog_full_reg;
   logic                     empty_reg;

   lane_response_arbiter_state_t state;
   logic [NUM_LANES_MAX-1:0] route_mask;
   logic [NUM_LANES_MAX-1:0] grant_reg;
   logic [PTR_W-1:0]         grant_idx;
   logic [PTR_W-1:0]         rr_ptr;
   logic [CNT_W-1:0]         burst_cnt;

   logic [NUM_LANES_MAX-1:0] eligible;
   logic [NUM_LANES_MAX-1:0] sel_eligible;
   logic [PTR_W-1:0]         sel_ptr;
   logic [PTR_W-1:0]         next_ptr;
   logic [NUM_LANES_MAX-1:0] sel_onehot;
   logic [PTR_W-1:0]         sel_idx;
   logic                     sel_found;
   logic                     cur_eligible;
   logic                     rd_en;
   logic                     burst_end;

   always_ff @(posedge ap_clk or negedge areset_n) begin
      if (!areset_n) begin
         cfg_valid_reg <= 1'b0;
         cfg_lane_reg  <= '0;
         req_reg       <= '0;
         prog_full_reg <= '0;
         empty_reg     <= 1'b0;
      end else begin
         cfg_valid_reg <= configure_route_valid;
         cfg_lane_reg  <= configure_route_in.id_lane[NUM_LANES_MAX-1:0];
         req_reg       <= lane_req_in;
         for (int i = 0; i < NUM_LANES_MAX; i++) begin
            prog_full_reg[i] <= fifo_response_lanes_backtrack_signals_in[i].prog_full;
         end
         empty_reg     <= fifo_response_engine_out_signals_in.empty;
      end
   end

   assign eligible     = req_reg & route_mask & ~prog_full_reg;
   assign cur_eligible = eligible[grant_idx];
   assign next_ptr     = (grant_idx == LAST_LANE) ? '0 : grant_idx + 1'b1;

   // In a burst the search for the follow-on lane starts just past the
   // current owner and skips it; grant_reg is zero outside a burst.
   assign sel_ptr      = (state == S_BURST) ? next_ptr : rr_ptr;
   assign sel_eligible = eligible & ~grant_reg;

   rr_priority_select #(
      .NUM_LANES (NUM_LANES_MAX),
      .PTR_W     (PTR_W)
   ) u_select (
      .eligible  (sel_eligible),
      .rr_ptr    (sel_ptr),
      .grant     (sel_onehot),
      .grant_idx (sel_idx),
      .found     (sel_found)
   );

   // A pending reconfiguration suppresses the read so no beat is issued to a
   // lane the new mask may exclude.
   assign rd_en     = (state == S_BURST) && cur_eligible && !empty_reg && !cfg_valid_reg;
   assign burst_end = (rd_en && (burst_cnt == LAST_BEAT)) || !cur_eligible;

   always_ff @(posedge ap_clk or negedge areset_n) begin
      if (!areset_n) begin
         state      <= S_UNCFG;
         route_mask <= '0;
         grant_reg  <= '0;
         grant_idx  <= '0;
         rr_ptr     <= '0;
         burst_cnt  <= '0;
      end else begin
         if (cfg_valid_reg) begin
            route_mask <= (|cfg_lane_reg) ? cfg_lane_reg : '1;
         end
         case (state)
            S_UNCFG: begin
               if (cfg_valid_reg) begin
                  state <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (!cfg_valid_reg && sel_found) begin
                  state     <= S_BURST;
                  grant_reg <= sel_onehot;
                  grant_idx <= sel_idx;
                  burst_cnt <= '0;
               end
            end
            S_BURST: begin
               if (cfg_valid_reg) begin
                  state     <= S_IDLE;
                  grant_reg <= '0;
                  burst_cnt <= '0;
               end else if (burst_end) begin
                  rr_ptr    <= next_ptr;
                  burst_cnt <= '0;
                  if (sel_found) begin
                     grant_reg <= sel_onehot;
                     grant_idx <= sel_idx;
                  end else begin
                     state     <= S_IDLE;
                     grant_reg <= '0;
                  end
               end else if (rd_en) begin
                  burst_cnt <= burst_cnt + 1'b1;
               end
            end
            default: begin
               state     <= S_UNCFG;
               grant_reg <= '0;
            end
         endcase
      end
   end

   assign grant_out       = grant_reg;
   assign grant_valid_out = (state == S_BURST);
   assign fifo_response_engine_in_signals_out = '{rd_en: rd_en, wr_en: 1'b0};

   // Status fields and identity parameters this block has no use for.
   logic [NUM_LANES_MAX-1:0] unused_lane_bits;
   logic                     unused_inputs;

   always_comb begin
      unused_lane_bits = '0;
      for (int i = 0; i < NUM_LANES_MAX; i++) begin
         unused_lane_bits[i] = fifo_response_lanes_backtrack_signals_in[i].full
                             ^ fifo_response_lanes_backtrack_signals_in[i].empty
                             ^ fifo_response_lanes_backtrack_signals_in[i].valid;
      end
   end

   assign unused_inputs = ^{configure_route_in.id_cu, configure_route_in.id_bundle,
                            configure_route_in.id_lane,
                            fifo_response_engine_out_signals_in.full,
                            fifo_response_engine_out_signals_in.prog_full,
                            fifo_response_engine_out_signals_in.valid,
                            unused_lane_bits, (ID_CU != 0), (ID_BUNDLE != 0),
                            (NUM_BUNDLES_MAX != 0)};

endmodule

// File: tb/tb_lane_response_rr_arbiter.sv
module tb_lane_response_rr_arbiter;
   import global_package::*;

   localparam int N = 4;
   localparam int B = 4;

   logic ap_clk = 1'b0;
   logic areset_n = 1'b0;
   always #5 ap_clk = ~ap_clk;

   logic                  cfg_v;
   MemoryPacketArbitrate  cfg_in;
   logic [N-1:0]          req;
   logic [N-1:0]          pf;
   logic                  eng_empty;
   FIFOStateSignalsOutput lane_sig [N-1:0];
   FIFOStateSignalsOutput eng_sig;
   FIFOStateSignalsInput  eng_ctl;
   logic [N-1:0]          grant;
   logic                  gvalid;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         lane_sig[i] = '{full: 1'b0, empty: 1'b0, prog_full: pf[i], valid: 1'b1};
      end
   end
   assign eng_sig = '{full: 1'b0, empty: eng_empty, prog_full: 1'b0, valid: ~eng_empty};

   lane_response_rr_arbiter #(
      .ID_CU(0), .ID_BUNDLE(0), .NUM_LANES_MAX(N), .NUM_BUNDLES_MAX(4), .BURST_MAX(B)
   ) dut (
      .ap_clk                                  (ap_clk),
      .areset_n                                (areset_n),
      .configure_route_valid                   (cfg_v),
      .configure_route_in                      (cfg_in),
      .lane_req_in                             (req),
      .fifo_response_lanes_backtrack_signals_in(lane_sig),
      .fifo_response_engine_out_signals_in     (eng_sig),
      .fifo_response_engine_in_signals_out     (eng_ctl),
      .grant_out                               (grant),
      .grant_valid_out                         (gvalid)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      tests++;
      fails++;
      $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
   endtask

   function automatic int oh2i(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   // ---------------- reference model ----------------
   // Lane ownership described as "owner lane, reads taken, next start lane".
   typedef struct { int gv; int g; int rd; } exp_t;
   exp_t exp_q[$];

   int           m_cfgd, m_owner, m_cnt, m_ptr;
   logic [N-1:0] m_mask, m_req_r, m_pf_r, m_cfg_lane_r;
   logic         m_empty_r, m_cfg_r;

   function automatic int m_elig(input int l);
      return (m_req_r[l] && m_mask[l] && !m_pf_r[l]) ? 1 : 0;
   endfunction

   function automatic int m_find(input int from, input int skip);
      for (int k = 0; k < N; k++) begin
         int l;
         l = (from + k) % N;
         if (l != skip && m_elig(l) == 1) return l;
      end
      return -1;
   endfunction

   function automatic int m_rd();
      if (m_owner < 0) return 0;
      return (m_elig(m_owner) == 1 && !m_empty_r && !m_cfg_r) ? 1 : 0;
   endfunction

   always @(posedge ap_clk) begin : model
      int rd, nxt;
      logic [N-1:0] newmask;
      exp_t e;
      if (!areset_n) begin
         m_cfgd = 0; m_owner = -1; m_cnt = 0; m_ptr = 0; m_mask = '0;
         m_req_r = '0; m_pf_r = '0; m_cfg_lane_r = '0; m_empty_r = 1'b0; m_cfg_r = 1'b0;
      end else begin
         newmask = (m_cfg_lane_r != '0) ? m_cfg_lane_r : '1;
         if (m_cfgd == 0) begin
            if (m_cfg_r) m_cfgd = 1;
         end else if (m_owner < 0) begin
            if (!m_cfg_r) begin
               nxt = m_find(m_ptr, -1);
               if (nxt >= 0) begin m_owner = nxt; m_cnt = 0; end
            end
         end else if (m_cfg_r) begin
            m_owner = -1; m_cnt = 0;
         end else begin
            rd = m_rd();
            if ((rd == 1 && m_cnt == B - 1) || m_elig(m_owner) == 0) begin
               m_ptr   = (m_owner + 1) % N;
               m_owner = m_find(m_ptr, m_owner);
               m_cnt   = 0;
            end else if (rd == 1) begin
               m_cnt++;
            end
         end
         if (m_cfg_r) m_mask = newmask;
         m_cfg_r = cfg_v; m_cfg_lane_r = cfg_in.id_lane[N-1:0];
         m_req_r = req; m_pf_r = pf; m_empty_r = eng_empty;
      end
      e.gv = (m_owner >= 0) ? 1 : 0;
      e.g  = (m_owner >= 0) ? (1 << m_owner) : 0;
      e.rd = m_rd();
      exp_q.push_back(e);
   end

   // ---------------- monitor ----------------
   int dut_log[$];
   int gv_seen = 0;

   always @(negedge ap_clk) begin : monitor
      exp_t e;
      if (exp_q.size() == 0) begin
         timeout_fail("scoreboard_underflow");
      end else begin
         e = exp_q.pop_front();
         check("grant_valid", int'(gvalid), e.gv);
         check("grant", int'(grant), e.g);
         check("rd_en", int'(eng_ctl.rd_en), e.rd);
      end
      if (gvalid) gv_seen++;
      if (eng_ctl.rd_en) dut_log.push_back(oh2i(grant));
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin @(posedge ap_clk); #2; end
   endtask

   task automatic configure(input logic [N-1:0] lanes);
      cfg_in.id_cu     = 8'($urandom);
      cfg_in.id_bundle = 8'($urandom);
      cfg_in.id_lane   = 8'(lanes);
      cfg_v = 1'b1;
      tick(1);
      cfg_v = 1'b0;
   endtask

   initial begin
      int odd, lane_l, got;
      logic [N-1:0] prev_g;
      cfg_v = 1'b0; cfg_in = '0; req = '0; pf = '0; eng_empty = 1'b0;
      tick(3);
      areset_n = 1'b1;
      tick(2);

      // rotation with mask all-ones
      req = '1;
      dut_log.delete();
      configure('0);
      tick(22);
      if (dut_log.size() >= 16) begin
         for (int i = 0; i < 16; i++) check("rotate_lane", dut_log[i], i / 4);
      end else check("rotate_read_count", dut_log.size(), 16);

      // asynchronous reset mid-burst
      got = 0;
      for (int t = 0; t < 50 && got == 0; t++) begin
         @(negedge ap_clk);
         if (eng_ctl.rd_en) got = 1;
      end
      if (got == 0) timeout_fail("reset_wait_rd");
      #1 areset_n = 1'b0;
      #1;
      check("reset_rd_en", int'(eng_ctl.rd_en), 0);
      check("reset_grant", int'(grant), 0);
      check("reset_grant_valid", int'(gvalid), 0);
      repeat (2) @(posedge ap_clk);
      @(negedge ap_clk);
      #1 areset_n = 1'b1;
      @(posedge ap_clk); #2;
      gv_seen = 0;
      tick(10);
      check("no_grant_until_cfg", gv_seen, 0);

      // lane mask 0101 alternates lanes 0 and 2
      dut_log.delete();
      configure(4'b0101);
      tick(36);
      odd = 0;
      foreach (dut_log[i]) if (dut_log[i] % 2 == 1) odd++;
      check("mask_odd_reads", odd, 0);
      if (dut_log.size() >= 16) begin
         for (int i = 0; i < 16; i++) check("mask_alternate", dut_log[i], ((i / 4) % 2) * 2);
      end else check("mask_read_count", dut_log.size(), 16);

      // reconfiguration mid-burst forces idle
      got = 0;
      for (int t = 0; t < 50 && got == 0; t++) begin
         if (gvalid && eng_ctl.rd_en) got = 1; else tick(1);
      end
      if (got == 0) timeout_fail("recfg_wait_burst");
      configure('0);
      check("recfg_rd_suppressed", int'(eng_ctl.rd_en), 0);
      check("recfg_still_burst", int'(gvalid), 1);
      tick(1);
      check("recfg_idle", int'(gvalid), 0);
      dut_log.delete();
      tick(20);
      odd = 0;
      foreach (dut_log[i]) if (dut_log[i] % 2 == 1) odd++;
      check("recfg_odd_granted", int'(odd > 0), 1);

      // prog_full on lane1 during its second read
      got = 0;
      for (int t = 0; t < 50 && got == 0; t++) begin
         @(negedge ap_clk);
         if (grant != 4'b0010) got = 1;
      end
      if (got == 0) timeout_fail("pf_wait_other");
      got = 0;
      for (int t = 0; t < 60 && got < 2; t++) begin
         @(negedge ap_clk);
         if (eng_ctl.rd_en && grant == 4'b0010) got++;
      end
      if (got < 2) timeout_fail("pf_wait_lane1");
      pf[1] = 1'b1;
      @(negedge ap_clk);
      check("pf_rd_drop", int'(eng_ctl.rd_en), 0);
      check("pf_grant_held", int'(grant), 2);
      @(negedge ap_clk);
      check("pf_next_lane2", int'(grant), 4);
      check("pf_lane2_read", int'(eng_ctl.rd_en), 1);
      pf[1] = 1'b0;
      tick(2);

      // engine empty for three cycles mid-burst
      got = 0;
      prev_g = grant;
      for (int t = 0; t < 50 && got == 0; t++) begin
         @(negedge ap_clk);
         if (gvalid && eng_ctl.rd_en && grant != prev_g) got = 1;
         prev_g = grant;
      end
      if (got == 0) timeout_fail("empty_wait_grant");
      lane_l = int'(grant);
      eng_empty = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge ap_clk);
         check("empty_grant_held", int'(grant), lane_l);
         check("empty_no_rd", int'(eng_ctl.rd_en), 0);
      end
      eng_empty = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge ap_clk);
         check("empty_resume_grant", int'(grant), lane_l);
         check("empty_resume_rd", int'(eng_ctl.rd_en), 1);
      end
      @(negedge ap_clk);
      check("empty_burst_done", int'(int'(grant) == lane_l), 0);
      tick(1);

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         pf = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '0;
         eng_empty = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 39) == 0) begin
            cfg_in.id_lane = 8'($urandom_range(0, 15));
            cfg_v = 1'b1;
         end else cfg_v = 1'b0;
         tick(1);
      end
      cfg_v = 1'b0;
      tick(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
